// File: rtl/adder_fp32_pkg.sv
// Shared types, constants and the fp32 classifier for the fp32 adder sequencer.
package adder_fp32_pkg;

    localparam int unsigned FP32_W = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;
    localparam int unsigned FLAG_W = 4;

    // Bit positions inside the {nan, inf, zero, denorm} flag vector
    localparam int unsigned FLAG_NAN    = 3;
    localparam int unsigned FLAG_INF    = 2;
    localparam int unsigned FLAG_ZERO   = 1;
    localparam int unsigned FLAG_DENORM = 0;

    localparam logic [FP32_W-1:0] FP32_QNAN = 32'hFFC0_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp32_t;

    typedef struct packed {
        fp32_t a;
        fp32_t b;
    } fp32_pair_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RES,
        ST_HOLD_OUT,
        ST_DRAIN
    } seq_state_t;

    // IEEE-754 class of a single-precision value
    function automatic logic [FLAG_W-1:0] fp32_classify(input fp32_t z);
        logic [FLAG_W-1:0] f;
        logic exp_max;
        logic exp_zero;
        logic mant_zero;
        exp_max   = (z.exp == '1);
        exp_zero  = (z.exp == '0);
        mant_zero = (z.mant == '0);
        f              = '0;
        f[FLAG_NAN]    = exp_max  && !mant_zero;
        f[FLAG_INF]    = exp_max  &&  mant_zero;
        f[FLAG_ZERO]   = exp_zero &&  mant_zero;
        f[FLAG_DENORM] = exp_zero && !mant_zero;
        return f;
    endfunction

endpackage

// File: rtl/fp32_pair_fifo.sv
// Synchronous FIFO of fp32 operand pairs with full/empty/count.
//   clk, arst_n      : clock, async active-low reset
//   push, wdata      : write request and pair (ignored when full)
//   pop              : read request (ignored when empty)
//   rdata_c          : head of the FIFO
//   full_c, empty_c  : occupancy status
//   count            : number of stored pairs
module fp32_pair_fifo
    import adder_fp32_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   push,
    input  fp32_pair_t             wdata,
    input  logic                   pop,
    output fp32_pair_t             rdata_c,
    output logic                   full_c,
    output logic                   empty_c,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    fp32_pair_t       mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign wr_en   = push && !full_c;
    assign rd_en   = pop && !empty_c;
    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign rdata_c = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    // Storage needs no reset: only slots below count are ever read out
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/adder_fp32_seq.sv
// Streaming wrapper around the fp32 adder: buffers operand pairs, issues
// them one at a time, collects each sum and presents it with class flags.
//   in_*            : operand-pair input stream (valid/ready)
//   add_*_o/add_*_i : adder issue (strobe/ready) and result (valid/ack) ports
//   out_*           : result stream (valid/ready) with {nan,inf,zero,denorm}
//   res_cnt_o       : completed results, wraps modulo 2^CNT_W
module adder_fp32_seq
    import adder_fp32_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_a_i,
    input  logic [31:0]      in_b_i,
    output logic             add_valid_stb_o,
    input  logic             add_ready_i,
    output logic [31:0]      add_a_o,
    output logic [31:0]      add_b_o,
    input  logic             add_valid_stb_i,
    input  logic [31:0]      add_z_i,
    output logic             add_ack_z_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_z_o,
    output logic [3:0]       out_flags_o,
    output logic [CNT_W-1:0] res_cnt_o
);

    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

    seq_state_t        state_q;
    seq_state_t        state_d;
    fp32_pair_t        head_c;
    logic              fifo_full_c;
    logic              fifo_empty_c;
    logic [FCNT_W-1:0] fifo_cnt;
    logic [FCNT_W-1:0] fifo_cnt_nxt_c;
    logic              push_c;
    logic              pop_c;
    logic              ready_d;
    logic              stb_d;
    logic [31:0]       a_d;
    logic [31:0]       b_d;
    logic              ack_d;
    logic              ov_d;
    logic [31:0]       z_d;
    logic [3:0]        flags_d;
    logic [CNT_W-1:0]  cnt_d;

    assign push_c = in_valid_i && in_ready_o && !fifo_full_c;

    fp32_pair_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .arst_n  (arst_n),
        .push    (push_c),
        .wdata   ({fp32_t'(in_a_i), fp32_t'(in_b_i)}),
        .pop     (pop_c),
        .rdata_c (head_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .count   (fifo_cnt)
    );

    // in_ready_o is registered, so it looks one edge ahead at the occupancy
    assign fifo_cnt_nxt_c = fifo_cnt + FCNT_W'(push_c) - FCNT_W'(pop_c);
    assign ready_d        = (fifo_cnt_nxt_c != FCNT_W'(FIFO_DEPTH));

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        pop_c   = 1'b0;
        stb_d   = 1'b0;
        ack_d   = 1'b0;
        a_d     = add_a_o;
        b_d     = add_b_o;
        ov_d    = out_valid_o;
        z_d     = out_z_o;
        flags_d = out_flags_o;
        cnt_d   = res_cnt_o;
        unique case (state_q)
            ST_IDLE: begin
                // A sum we never issued (e.g. from before a local reset) is flushed first
                if (add_valid_stb_i) begin
                    ack_d   = 1'b1;
                    state_d = ST_DRAIN;
                end else if (!fifo_empty_c && add_ready_i) begin
                    pop_c   = 1'b1;
                    a_d     = head_c.a;
                    b_d     = head_c.b;
                    stb_d   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (add_valid_stb_i) begin
                    z_d     = add_z_i;
                    flags_d = fp32_classify(fp32_t'(add_z_i));
                    ov_d    = 1'b1;
                    ack_d   = 1'b1;
                    cnt_d   = res_cnt_o + CNT_W'(1);
                    state_d = ST_HOLD_OUT;
                end
            end
            ST_HOLD_OUT: begin
                if (out_ready_i) begin
                    ov_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q         <= ST_IDLE;
            in_ready_o      <= 1'b0;
            add_valid_stb_o <= 1'b0;
            add_a_o         <= '0;
            add_b_o         <= '0;
            add_ack_z_o     <= 1'b0;
            out_valid_o     <= 1'b0;
            out_z_o         <= '0;
            out_flags_o     <= '0;
            res_cnt_o       <= '0;
        end else begin
            state_q         <= state_d;
            in_ready_o      <= ready_d;
            add_valid_stb_o <= stb_d;
            add_a_o         <= a_d;
            add_b_o         <= b_d;
            add_ack_z_o     <= ack_d;
            out_valid_o     <= ov_d;
            out_z_o         <= z_d;
            out_flags_o     <= flags_d;
            res_cnt_o       <= cnt_d;
        end
    end

endmodule
